multiport_register_file: RTL
============================

Name: multiport_register_file

Overview:
Parametrised successor to the single-write, dual-read integer register file used by the pipelined core.
- Configurable width, register count, number of read ports and number of write ports.
- Same-cycle write-to-read bypass.
- Per-register pending-write scoreboard (busy bits) for decode-stage hazard detection.
- Sits between decode (read and issue) and writeback (write) in the pipelined datapath.

Parameters:
- XLEN, 64, data width of every register.
- NREGS, 32, number of architectural registers; power of two, at least 2. AW = clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  output  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- rd_busy  output  NRD  port k: the addressed register has a pending write.
- wr_en  input  NWR  per-port write enable.
- wr_addr  input  NWR*AW  write addresses, packed as for rd_addr.
- wr_data  input  NWR*XLEN  write data, packed as for rd_data.
- iss_en  input  1  issue event: mark iss_addr as pending.
- iss_addr  input  AW  destination register of the issuing instruction.
- flush  input  1  clear all busy bits (pipeline flush).
- busy_any  output  1  OR of all busy bits.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: all registers 0 and all busy bits 0. While rst is high, rd_data = 0, rd_busy = 0, busy_any = 0, and bypass is disabled.
- Register 0:
  - Reads as 0 always.
  - Writes to address 0 are discarded and never bypassed.
  - Never marked busy (iss_en with iss_addr = 0 is ignored).
- Writes:
  - On the rising edge, each port j with wr_en[j] = 1 and wr_addr[j] != 0 stores wr_data[j].
  - Collision (two or more enabled ports, same address): the highest-index port wins. Lower-index data is dropped with no error.
- Reads are combinational, zero latency.
  - rd_data[k] = 0 if rd_addr[k] = 0.
  - Otherwise, if any enabled write port targets rd_addr[k] this cycle, rd_data[k] = wr_data of the highest-index such port (bypass).
  - Otherwise rd_data[k] = stored value.
- Scoreboard, per register r != 0, updated on the rising edge:
  - flush = 1: busy[r] <= 0 for all r. Flush overrides issue and write in the same cycle.
  - Otherwise, iss_en = 1 and iss_addr = r: busy[r] <= 1. This holds even if a write to r occurs in the same cycle (the new producer takes precedence).
  - Otherwise, any enabled write port targets r: busy[r] <= 0.
  - Otherwise busy[r] holds.
- rd_busy[k] = busy[rd_addr[k]], with one exception: it is forced to 0 when an enabled write to rd_addr[k] is bypassing this cycle, because the data is valid now.
- busy_any = OR over busy[1..NREGS-1], registered state only (no bypass term).
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. After deassertion, the first edge behaves as from power-up.
- No X propagation: every output is driven from defined state at all times.

Optional Feature:
- Macro: REGFILE_DEBUG_EN.
- Defined:
  - Adds ports dbg_addr (input, AW) and dbg_data (output, XLEN). dbg_data is the combinational stored value, with no bypass.
  - Adds wr_count (output, 32): counts rising edges with at least one committed write to a nonzero register. Reset to 0; wraps from 2^32-1 to 0.
- Undefined: these ports and the counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then read all ports at addresses 0..31 -> all rd_data = 0, rd_busy = 0, busy_any = 0.
2. wr_en = 01, wr_addr[0] = 5, wr_data[0] = 64'hDEAD_BEEF, with rd_addr[0] = 5 in the same cycle -> rd_data[0] = DEAD_BEEF that cycle (bypass). Next cycle, with wr_en = 0, rd_data[0] still DEAD_BEEF.
3. Both write ports target register 7 with data 0x11 (port 0) and 0x22 (port 1) -> bypass shows 0x22 and stored value is 0x22. Write 0x99 to register 0 -> reads 0.
4. iss_en with iss_addr = 3 -> next cycle rd_busy = 1 for port reading 3, busy_any = 1. Write to 3 -> rd_busy = 0 that cycle via bypass, busy clears next edge, busy_any = 0.
5. In one cycle: iss_en on 4 plus write to 4 -> busy[4] = 1 after the edge. Then issue 6 and 9, then flush -> all busy = 0 after the edge.
6. Write 0x55 to register 10, assert rst asynchronously mid-cycle -> rd_data immediately 0. After release, reading register 10 returns 0. With REGFILE_DEBUG_EN, wr_count = 0.

Source files
------------

// File: rtl/multiport_register_file_if.sv
// Bus interface for multiport_register_file: read ports, write ports,
// issue/flush scoreboard controls and the busy summary.
// Optional debug port group is present only when REGFILE_DEBUG_EN is defined.
interface multiport_register_file_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic                busy_any;
`ifdef REGFILE_DEBUG_EN
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;
    logic [31:0]         wr_count;
`endif

    // Pipeline side: decode/writeback drive addresses, data and controls
    modport master (
`ifdef REGFILE_DEBUG_EN
        output dbg_addr,
        input  dbg_data,
        input  wr_count,
`endif
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_any
    );

    // Register file side
    modport slave (
`ifdef REGFILE_DEBUG_EN
        input  dbg_addr,
        output dbg_data,
        output wr_count,
`endif
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_any
    );
endinterface

// File: rtl/multiport_register_file.sv
// Multi-port integer register file with same-cycle write-to-read bypass and
// a per-register pending-write scoreboard for decode hazard detection.
// Register 0 is hardwired to zero and is never marked busy.
// Optional macro REGFILE_DEBUG_EN adds a raw debug read port and a counter of
// clock edges that committed at least one write.
module multiport_register_file #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    multiport_register_file_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic [NREGS-1:0] w_wrHit;
    logic [XLEN-1:0]  w_wrVal [NREGS];

    // Resolve all write ports per register; later (higher) ports override earlier ones
    always_comb begin
        w_wrHit = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_wrVal[r] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != '0)) begin
                w_wrHit[bus.wr_addr[j*AW +: AW]] = 1'b1;
                w_wrVal[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Register storage; entry 0 is only ever cleared so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (w_wrHit[r]) begin
                    r_regs[r] <= w_wrVal[r];
                end
            end
        end
    end

    // Scoreboard: flush beats issue, a new issue beats a completing write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (bus.flush) begin
            r_busy <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
                    r_busy[r] <= 1'b1;
                end else if (w_wrHit[r]) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = bus.rd_addr[k*AW +: AW];

        // Read mux: zero register, then bypass from this cycle's writes, then storage
        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (!rst && (w_addr != '0)) begin
                if (w_wrHit[w_addr]) begin
                    w_data = w_wrVal[w_addr];
                end else begin
                    w_data = r_regs[w_addr];
                    w_busy = r_busy[w_addr];
                end
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] = w_data;
        assign bus.rd_busy[k]              = w_busy;
    end

    assign bus.busy_any = !rst && (|r_busy);

`ifdef REGFILE_DEBUG_EN
    assign bus.dbg_data = r_regs[bus.dbg_addr];

    logic [31:0] r_wrCount;

    // Count edges on which any nonzero register was written; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrCount <= '0;
        end else if (|w_wrHit) begin
            r_wrCount <= r_wrCount + 32'd1;
        end
    end

    assign bus.wr_count = r_wrCount;
`endif

endmodule
